msi_snoop_responder: RTL and testbench
======================================

MSI_SNOOP_RESPONDER -- requirements
Module: msi_snoop_responder

Interface
REQ-001 LINES, 4, number of direct-mapped L1 lines; power of two; index = Address[log2(LINES)-1:0].
REQ-002 Clock  input  1  single clock, rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ReqValid  input  1  directory request present.
REQ-005 ReqReady  output  1  responder accepts request this cycle.
REQ-006 ReqCmd  input  2  01 INV, 10 FETCH, 11 FETCH_INV, 00 reserved.
REQ-007 ReqAddress  input  4  block address, 0000 = empty.
REQ-008 RespValid  output  1  response present.
REQ-009 RespReady  input  1  directory consumes response.
REQ-010 RespCode  output  2  00 none, 01 ACK, 10 ACK_DATA, 11 NACK.
REQ-011 RespAddress  output  4  echo of accepted ReqAddress.
REQ-012 RespData  output  4  line data on ACK_DATA, else 0000.
REQ-013 FillValid  input  1  processor-side line install/update.
REQ-014 FillAddress / FillState / FillData  input  4/3/4  line tag, MSI state, data.
REQ-015 FillDrop  output  1  one-cycle pulse: fill discarded by collision.
REQ-016 ProbeAddress  input  4  processor hit lookup address.
REQ-017 ProbeState  output  3  combinational state of matching line, 001 (I) on tag mismatch.

Function
REQ-018 State encodings SHALL be empty 000, I 001, S 010, M 011; a line hits only if stored tag == address and state is S or M.
REQ-019 FSM states SHALL be IDLE, LOOKUP, RESPOND; ReqReady=1 only in IDLE.
REQ-020 ReqValid&&ReqReady at edge N SHALL latch cmd/address and enter LOOKUP; RespValid SHALL assert at edge N+2.
REQ-021 LOOKUP SHALL last exactly one cycle, compute response and write next line state at its closing edge.
REQ-022 INV: M->I ACK_DATA; S->I ACK; miss ACK.
REQ-023 FETCH: M->S ACK_DATA; S unchanged ACK; miss ACK.
REQ-024 FETCH_INV: M->I ACK_DATA; S->I ACK; miss ACK.
REQ-025 Reserved cmd 00 SHALL return NACK with no array change; ReqAddress 0000 SHALL be a miss.
REQ-026 In RESPOND, RespValid/RespCode/RespAddress/RespData SHALL stay stable until RespReady; on handshake return to IDLE, RespValid low next cycle, RespCode 00, RespData 0000.
REQ-027 Minimum request spacing SHALL be 3 cycles; no request pipelining.
REQ-028 FillValid SHALL write tag/state/data at index in any FSM state; FillState 000/001 invalidates line.
REQ-029 Fill and LOOKUP update to same index in same cycle: snoop update wins, fill discarded, FillDrop=1 that cycle.
REQ-030 Fill to the index latched for a pending LOOKUP one cycle earlier SHALL be visible to that LOOKUP (write-then-read ordering).
REQ-031 Tag SHALL store full 4-bit address; aliasing index with different tag is a miss, line untouched.

Reset
REQ-032 Reset_n low SHALL asynchronously set all lines to state 000, tag 0000, data 0000; FSM IDLE; RespValid 0, RespCode 00, RespAddress 0000, RespData 0000, FillDrop 0.
REQ-033 ReqReady SHALL be 0 while Reset_n low and 1 from the first edge after release.
REQ-034 Reset mid-transaction SHALL abort it; no response issued afterwards.

Structure
REQ-035 Package msi_pkg SHALL hold state, address, data encodings and ReqCmd/RespCode constants, shared with directory and processor blocks.
REQ-036 Storage SHALL be sub-module msi_line_array: LINES entries, one combinational probe read, one lookup read, prioritized snoop/fill write ports.

Verification
REQ-037 Fill 0001/M/0110, then INV 0001 -> RespCode 10, RespData 0110, ProbeState(0001)=001, RespValid at accept+2.
REQ-038 Fill 0010/M/1000, FETCH 0010 -> ACK_DATA 1000, line S; second FETCH -> ACK, data 0000.
REQ-039 Fill 0011/S, FETCH_INV 0011 -> ACK, line I; INV 0101 (empty) -> ACK, no change.
REQ-040 Snoop LOOKUP and fill same index same cycle -> FillDrop=1, snoop result stored; ReqCmd 00 -> NACK.
REQ-041 RespReady low 5 cycles -> outputs stable, ReqReady 0; Reset_n low in LOOKUP -> no response, all lines 000.

Source files
------------

// File: rtl/msi_pkg.sv
// ============================================================================
// Module : msi_pkg
// Shared MSI encodings, address/data types and request/response codes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package msi_pkg;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 4;
  localparam int STATE_W = 3;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_EMPTY = 3'b000;
  localparam state_t ST_I     = 3'b001;
  localparam state_t ST_S     = 3'b010;
  localparam state_t ST_M     = 3'b011;

  localparam logic [1:0] CMD_RSVD      = 2'b00;
  localparam logic [1:0] CMD_INV       = 2'b01;
  localparam logic [1:0] CMD_FETCH     = 2'b10;
  localparam logic [1:0] CMD_FETCH_INV = 2'b11;

  localparam logic [1:0] RESP_NONE     = 2'b00;
  localparam logic [1:0] RESP_ACK      = 2'b01;
  localparam logic [1:0] RESP_ACK_DATA = 2'b10;
  localparam logic [1:0] RESP_NACK     = 2'b11;

  function automatic logic is_valid_state(input state_t s);
    return (s == ST_S) || (s == ST_M);
  endfunction

endpackage

`default_nettype wire

// File: rtl/msi_line_array.sv
// ============================================================================
// Module : msi_line_array
// Direct-mapped tag/state/data store; snoop write has priority over fill.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module msi_line_array
  import msi_pkg::*;
#(
  parameter int LINES = 4,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] probe_index,
  output addr_t            probe_tag,
  output state_t           probe_state,
  input  logic [IDX_W-1:0] lookup_index,
  output addr_t            lookup_tag,
  output state_t           lookup_state,
  output data_t            lookup_data,
  input  logic             snoop_we,
  input  logic [IDX_W-1:0] snoop_index,
  input  state_t           snoop_state,
  input  logic             fill_we,
  input  logic [IDX_W-1:0] fill_index,
  input  addr_t            fill_tag,
  input  state_t           fill_state,
  input  data_t            fill_data,
  output logic             fill_drop
);

  addr_t  tag_q   [LINES];
  state_t state_q [LINES];
  data_t  data_q  [LINES];

  assign probe_tag    = tag_q[probe_index];
  assign probe_state  = state_q[probe_index];
  assign lookup_tag   = tag_q[lookup_index];
  assign lookup_state = state_q[lookup_index];
  assign lookup_data  = data_q[lookup_index];

  assign fill_drop = fill_we && snoop_we && (fill_index == snoop_index);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]   <= '0;
        state_q[i] <= ST_EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      if (fill_we && !fill_drop) begin
        tag_q[fill_index]   <= fill_tag;
        state_q[fill_index] <= fill_state;
        data_q[fill_index]  <= fill_data;
      end
      if (snoop_we) begin
        state_q[snoop_index] <= snoop_state;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/msi_snoop_responder.sv
// ============================================================================
// Module : msi_snoop_responder
// L1-side MSI snoop responder: IDLE -> LOOKUP -> RESPOND per directory request.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module msi_snoop_responder
  import msi_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_cmd,
  input  logic [3:0]   req_address,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [1:0]   resp_code,
  output logic [3:0]   resp_address,
  output logic [3:0]   resp_data,
  input  logic         fill_valid,
  input  logic [3:0]   fill_address,
  input  logic [2:0]   fill_state,
  input  logic [3:0]   fill_data,
  output logic         fill_drop,
  input  logic [3:0]   probe_address,
  output logic [2:0]   probe_state
);

  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    RESPOND = 2'd2
  } fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic       started_q;
  logic [1:0] cmd_q;
  addr_t      addr_q;
  logic       resp_valid_q;
  logic [1:0] resp_code_q;
  addr_t      resp_addr_q;
  data_t      resp_data_q;

  addr_t      lk_tag, pr_tag;
  state_t     lk_state, pr_state, lk_next;
  data_t      lk_data, lk_resp_data;
  logic [1:0] lk_code;
  logic       lk_hit, snoop_we, accept;

  msi_line_array #(.LINES(LINES), .IDX_W(IDX_W)) u_lines (
    .clock        (clock),
    .reset_n      (reset_n),
    .probe_index  (probe_address[IDX_W-1:0]),
    .probe_tag    (pr_tag),
    .probe_state  (pr_state),
    .lookup_index (addr_q[IDX_W-1:0]),
    .lookup_tag   (lk_tag),
    .lookup_state (lk_state),
    .lookup_data  (lk_data),
    .snoop_we     (snoop_we),
    .snoop_index  (addr_q[IDX_W-1:0]),
    .snoop_state  (lk_next),
    .fill_we      (fill_valid),
    .fill_index   (fill_address[IDX_W-1:0]),
    .fill_tag     (fill_address),
    .fill_state   (fill_state),
    .fill_data    (fill_data),
    .fill_drop    (fill_drop)
  );

  assign probe_state = (pr_tag == probe_address) ? pr_state : ST_I;

  // Address 0000 denotes an empty slot and never hits, whatever was filled there.
  assign lk_hit = (addr_q != '0) && (lk_tag == addr_q) && is_valid_state(lk_state);

  always_comb begin
    lk_next      = lk_state;
    lk_code      = RESP_ACK;
    lk_resp_data = '0;
    if (cmd_q == CMD_RSVD) begin
      lk_code = RESP_NACK;
    end else if (lk_hit) begin
      lk_next = (cmd_q == CMD_FETCH) ? ST_S : ST_I;
      if (lk_state == ST_M) begin
        lk_code      = RESP_ACK_DATA;
        lk_resp_data = lk_data;
      end
    end
  end

  // Every non-reserved LOOKUP owns the line write port, even when the state is unchanged.
  assign snoop_we  = (fsm_q == LOOKUP) && (cmd_q != CMD_RSVD);
  assign req_ready = (fsm_q == IDLE) && started_q;
  assign accept    = req_valid && req_ready;

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (accept) fsm_d = LOOKUP;
      LOOKUP:  fsm_d = RESPOND;
      RESPOND: if (resp_valid_q && resp_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fsm_q <= IDLE;
    else          fsm_q <= fsm_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      started_q    <= 1'b0;
      cmd_q        <= CMD_RSVD;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= RESP_NONE;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
    end else begin
      started_q <= 1'b1;
      if (accept) begin
        cmd_q  <= req_cmd;
        addr_q <= req_address;
      end
      if (fsm_q == LOOKUP) begin
        resp_code_q <= lk_code;
        resp_addr_q <= addr_q;
        resp_data_q <= lk_resp_data;
      end
      // Valid rises one cycle after the response is captured, then holds until taken.
      if (fsm_q == RESPOND) begin
        if (!resp_valid_q) begin
          resp_valid_q <= 1'b1;
        end else if (resp_ready) begin
          resp_valid_q <= 1'b0;
          resp_code_q  <= RESP_NONE;
          resp_data_q  <= '0;
        end
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_code    = resp_code_q;
  assign resp_address = resp_addr_q;
  assign resp_data    = resp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_msi_snoop_responder.sv
// ============================================================================
// Module : tb_msi_snoop_responder
// Randomized bench for msi_snoop_responder against a line-table reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_msi_snoop_responder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready;
  logic [1:0] req_cmd;
  logic [3:0] req_address;
  logic       resp_valid, resp_ready;
  logic [1:0] resp_code;
  logic [3:0] resp_address, resp_data;
  logic       fill_valid;
  logic [3:0] fill_address;
  logic [2:0] fill_state;
  logic [3:0] fill_data;
  logic       fill_drop;
  logic [3:0] probe_address;
  logic [2:0] probe_state;

  int checks = 0;
  int errors = 0;

  // Reference line table: tag, MSI state and data per index
  logic [3:0] m_tag  [4];
  logic [2:0] m_st   [4];
  logic [3:0] m_data [4];

  logic [1:0] oc;
  logic [3:0] od;

  msi_snoop_responder #(.LINES(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cmd       (req_cmd),
    .req_address   (req_address),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_code     (resp_code),
    .resp_address  (resp_address),
    .resp_data     (resp_data),
    .fill_valid    (fill_valid),
    .fill_address  (fill_address),
    .fill_state    (fill_state),
    .fill_data     (fill_data),
    .fill_drop     (fill_drop),
    .probe_address (probe_address),
    .probe_state   (probe_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_tag[i] = 4'h0; m_st[i] = 3'b000; m_data[i] = 4'h0;
    end
  endtask

  task automatic model_fill(input logic [3:0] a, input logic [2:0] s, input logic [3:0] d);
    m_tag[a[1:0]] = a; m_st[a[1:0]] = s; m_data[a[1:0]] = d;
  endtask

  task automatic probe_check(input logic [3:0] a);
    logic [2:0] exp;
    probe_address = a;
    #1;
    exp = (m_tag[a[1:0]] == a) ? m_st[a[1:0]] : 3'b001;
    check("probe_state", {29'd0, probe_state}, {29'd0, exp});
  endtask

  // Fill while the responder is idle
  task automatic do_fill(input logic [3:0] a, input logic [2:0] s, input logic [3:0] d);
    fill_valid = 1'b1; fill_address = a; fill_state = s; fill_data = d;
    @(posedge clock); #1;
    fill_valid = 1'b0;
    model_fill(a, s, d);
  endtask

  // fmode: 0 no fill, 1 fill alongside the accepted request, 2 fill during LOOKUP
  task automatic do_req(input logic [1:0] cmd, input logic [3:0] a, input int fmode,
                        input logic [3:0] fa, input logic [2:0] fs, input logic [3:0] fd,
                        input int hold, output logic [1:0] got_c, output logic [3:0] got_d);
    int         i;
    logic [2:0] st, ns;
    logic [1:0] ec;
    logic [3:0] ed;
    bit         hit, wr, drop;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_cmd = cmd; req_address = a;
    if (fmode == 1) begin
      fill_valid = 1'b1; fill_address = fa; fill_state = fs; fill_data = fd;
    end
    @(posedge clock); #1;
    req_valid  = 1'b0;
    fill_valid = 1'b0;
    if (fmode == 1) model_fill(fa, fs, fd);
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);

    i   = int'(a[1:0]);
    st  = m_st[i];
    hit = (a != 4'h0) && (m_tag[i] == a) && (st == 3'b010 || st == 3'b011);
    ns  = st; ec = 2'b01; ed = 4'h0;
    if (cmd == 2'b00) ec = 2'b11;
    else if (hit) begin
      ns = (cmd == 2'b10) ? 3'b010 : 3'b001;
      if (st == 3'b011) begin ec = 2'b10; ed = m_data[i]; end
    end
    wr   = (cmd != 2'b00);
    drop = (fmode == 2) && wr && (int'(fa[1:0]) == i);

    if (fmode == 2) begin
      fill_valid = 1'b1; fill_address = fa; fill_state = fs; fill_data = fd;
      #1;
      check("fill_drop", {31'd0, fill_drop}, {31'd0, drop});
    end
    @(posedge clock); #1;
    fill_valid = 1'b0;
    if (fmode == 2 && !drop) model_fill(fa, fs, fd);
    if (wr) m_st[i] = ns;
    check("resp_valid_early", {31'd0, resp_valid}, 32'd0);

    @(posedge clock); #1;
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_code", {30'd0, resp_code}, {30'd0, ec});
    check("resp_address", {28'd0, resp_address}, {28'd0, a});
    check("resp_data", {28'd0, resp_data}, {28'd0, ed});
    got_c = resp_code; got_d = resp_data;
    for (int k = 0; k < hold; k++) begin
      @(posedge clock); #1;
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_code", {30'd0, resp_code}, {30'd0, ec});
      check("hold_data", {28'd0, resp_data}, {28'd0, ed});
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("post_valid", {31'd0, resp_valid}, 32'd0);
    check("post_code", {30'd0, resp_code}, 32'd0);
    check("post_data", {28'd0, resp_data}, 32'd0);
  endtask

  initial begin
    logic [3:0] a, fa;
    int         op, fm;
    reset_n = 1'b0; req_valid = 1'b0; req_cmd = 2'b00; req_address = 4'h0;
    resp_ready = 1'b0; fill_valid = 1'b0; fill_address = 4'h0; fill_state = 3'b000;
    fill_data = 4'h0; probe_address = 4'h0;
    model_clear();

    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_code", {30'd0, resp_code}, 32'd0);
    check("rst_resp_addr", {28'd0, resp_address}, 32'd0);
    check("rst_resp_data", {28'd0, resp_data}, 32'd0);
    check("rst_fill_drop", {31'd0, fill_drop}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clock); #1;
    check("first_req_ready", {31'd0, req_ready}, 32'd1);

    // Directed scenarios
    do_fill(4'h1, 3'b011, 4'h6);
    do_req(2'b01, 4'h1, 0, 4'h0, 3'b000, 4'h0, 0, oc, od);
    check("inv_m_code", {30'd0, oc}, 32'd2);
    check("inv_m_data", {28'd0, od}, 32'd6);
    probe_check(4'h1);

    do_fill(4'h2, 3'b011, 4'h8);
    do_req(2'b10, 4'h2, 0, 4'h0, 3'b000, 4'h0, 0, oc, od);
    check("fetch_m_code", {30'd0, oc}, 32'd2);
    check("fetch_m_data", {28'd0, od}, 32'd8);
    probe_check(4'h2);
    do_req(2'b10, 4'h2, 0, 4'h0, 3'b000, 4'h0, 0, oc, od);
    check("fetch_s_code", {30'd0, oc}, 32'd1);
    check("fetch_s_data", {28'd0, od}, 32'd0);

    do_fill(4'h3, 3'b010, 4'h5);
    do_req(2'b11, 4'h3, 0, 4'h0, 3'b000, 4'h0, 0, oc, od);
    check("finv_s_code", {30'd0, oc}, 32'd1);
    probe_check(4'h3);
    do_req(2'b01, 4'h5, 0, 4'h0, 3'b000, 4'h0, 0, oc, od);
    check("inv_miss_code", {30'd0, oc}, 32'd1);
    probe_check(4'h1);

    do_fill(4'h6, 3'b011, 4'h9);
    do_req(2'b10, 4'h6, 2, 4'h6, 3'b001, 4'h0, 0, oc, od);
    probe_check(4'h6);
    do_req(2'b00, 4'h6, 0, 4'h0, 3'b000, 4'h0, 0, oc, od);
    check("nack_code", {30'd0, oc}, 32'd3);

    do_req(2'b01, 4'h7, 1, 4'h7, 3'b011, 4'h4, 0, oc, od);
    check("fill_fwd_code", {30'd0, oc}, 32'd2);
    check("fill_fwd_data", {28'd0, od}, 32'd4);
    do_fill(4'hB, 3'b011, 4'hA);
    do_req(2'b10, 4'hB, 0, 4'h0, 3'b000, 4'h0, 5, oc, od);

    // Reset while the request is in LOOKUP
    do_fill(4'hC, 3'b011, 4'h3);
    req_valid = 1'b1; req_cmd = 2'b01; req_address = 4'hC;
    @(posedge clock); #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    model_clear();
    check("abort_req_ready", {31'd0, req_ready}, 32'd0);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_resp_code", {30'd0, resp_code}, 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    probe_check(4'h0);
    probe_check(4'hC);
    do_req(2'b01, 4'hC, 0, 4'h0, 3'b000, 4'h0, 0, oc, od);

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      op = int'($urandom_range(0, 3));
      a  = 4'($urandom_range(0, 7));
      if (op == 0) begin
        do_fill(a, 3'($urandom_range(0, 3)), 4'($urandom));
      end else begin
        fm = int'($urandom_range(0, 2));
        fa = ($urandom_range(0, 1) == 0) ? a : 4'($urandom_range(0, 7));
        do_req(2'($urandom_range(0, 3)), a, fm, fa, 3'($urandom_range(0, 3)),
               4'($urandom), int'($urandom_range(0, 2)), oc, od);
      end
      probe_check(4'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
